// File: rtl/alu_md_pkg.sv
// alu_md_pkg: shared definitions for the alu_md_unit execute block.
//   - 5-bit op codes: op[4]=0 selects the base ALU, op[4]=1 the M-extension.
//   - FSM state encoding for the iterative mul/div sequencer.
package alu_md_pkg;

  // Base ALU op codes (op[4] = 0)
  localparam logic [4:0] ADD    = 5'b0_0000;
  localparam logic [4:0] SUB    = 5'b0_0001;
  localparam logic [4:0] SLT    = 5'b0_0010;
  localparam logic [4:0] SLTU   = 5'b0_0011;
  localparam logic [4:0] SLL    = 5'b0_0100;
  localparam logic [4:0] XOR    = 5'b0_0101;
  localparam logic [4:0] SRL    = 5'b0_0110;
  localparam logic [4:0] SRA    = 5'b0_0111;
  localparam logic [4:0] OR     = 5'b0_1000;
  localparam logic [4:0] AND    = 5'b0_1001;
  localparam logic [4:0] NOP    = 5'b0_1010;
  localparam logic [4:0] GE     = 5'b0_1011;

  // M-extension op codes (op[4] = 1, op[2:0] selects the operation)
  localparam logic [4:0] MUL    = 5'b1_0000;
  localparam logic [4:0] MULH   = 5'b1_0001;
  localparam logic [4:0] MULHSU = 5'b1_0010;
  localparam logic [4:0] MULHU  = 5'b1_0011;
  localparam logic [4:0] DIV    = 5'b1_0100;
  localparam logic [4:0] DIVU   = 5'b1_0101;
  localparam logic [4:0] REM    = 5'b1_0110;
  localparam logic [4:0] REMU   = 5'b1_0111;

  // Bit of op that flags an M-extension operation
  localparam int M_BIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_md_seq.sv
// alu_md_seq: iterative unsigned multiply / restoring divide datapath.
//   Runs exactly XLEN iterations after start, one per clock.
//   Multiply: shift-add, {hi,lo} holds the 2*XLEN product at the end.
//   Divide:   restoring, lo holds the quotient and hi the remainder.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          abandons the current iteration run
//   start          load magnitudes and begin (ignored while flush)
//   a_mag, b_mag   unsigned operands (multiplicand/multiplier or dividend/divisor)
//   is_div         1 = divide, 0 = multiply
//   done           high during the cycle whose clock edge performs the last iteration
//   q, hi, lo      quotient, high word (product hi / remainder), low word
module alu_md_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  input  logic            is_div,
  output logic            done,
  output logic [XLEN-1:0] q,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] hi_reg, lo_reg, b_reg;
  logic [XLEN-1:0] hi_next, lo_next;
  logic [CW-1:0]   cnt_reg;
  logic            run_reg, div_reg;
  logic [XLEN:0]   add_sum, shifted, trial;

  always_comb begin
    // Multiply step: conditionally add multiplicand into the high word,
    // then shift the whole {carry,hi,lo} right by one.
    add_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
    // Divide step: bring in the next dividend bit and try a subtract.
    shifted = {hi_reg, lo_reg[XLEN-1]};
    trial   = shifted - {1'b0, b_reg};
    hi_next = add_sum[XLEN:1];
    lo_next = {add_sum[0], lo_reg[XLEN-1:1]};
    if (div_reg) begin
      if (!trial[XLEN]) begin
        hi_next = trial[XLEN-1:0];
        lo_next = {lo_reg[XLEN-2:0], 1'b1};
      end else begin
        hi_next = shifted[XLEN-1:0];
        lo_next = {lo_reg[XLEN-2:0], 1'b0};
      end
    end
  end

  assign done = run_reg && (cnt_reg == CW'(XLEN-1));
  assign q    = lo_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg  <= '0;
      lo_reg  <= '0;
      b_reg   <= '0;
      cnt_reg <= '0;
      run_reg <= 1'b0;
      div_reg <= 1'b0;
    end else if (flush) begin
      run_reg <= 1'b0;
      cnt_reg <= '0;
    end else if (start) begin
      hi_reg  <= '0;
      lo_reg  <= a_mag;
      b_reg   <= b_mag;
      div_reg <= is_div;
      cnt_reg <= '0;
      run_reg <= 1'b1;
    end else if (run_reg) begin
      hi_reg  <= hi_next;
      lo_reg  <= lo_next;
      cnt_reg <= cnt_reg + CW'(1);
      if (done) run_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_md_unit.sv
// alu_md_unit: RV32I ALU plus M-extension execute unit with valid/ready
// handshakes on both sides and a registered result.
// Base ops complete in 1 cycle; M ops iterate (latency XLEN+2) except the
// divide-by-zero and signed-overflow divide cases, which complete in 1 cycle.
// Build option: define ALU_MD_FAST_MUL_EN to make mul/mulh/mulhsu/mulhu a
// single-cycle combinational multiply; div/rem stay iterative.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 aborts any op in flight or result held in the output
//   in_valid / in_ready   input handshake; op, rs1_data, rs2_data operands
//   out_valid / out_ready output handshake; result, zero, overflow
module alu_md_unit
  import alu_md_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            overflow
);

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_reg, state_next;
  logic            out_valid_reg, zero_reg, overflow_reg, neg_reg;
  logic [XLEN-1:0] result_reg;
  logic [2:0]      m_op_reg;

  logic            accept, is_m, iterative, fast_mul;
  logic            a_signed, b_signed, a_neg, b_neg, res_neg;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] add_res, sub_res, base_res, imm_res, md_res;
  logic            base_ovf, imm_ovf;
  logic [SHW-1:0]  shamt;
  logic            seq_done;
  logic [XLEN-1:0] seq_q, seq_hi, seq_lo;
  logic [2*XLEN-1:0] prod_mag, prod_seq;

  assign in_ready  = (state_reg == IDLE) && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign overflow  = overflow_reg;

  // Operand sign decode: div/rem signed when op[0]=0; mulh both signed,
  // mulhsu only rs1 signed. mul low word is sign-agnostic, so it runs unsigned.
  assign is_m     = op[M_BIT];
  assign a_signed = op[2] ? !op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
  assign b_signed = op[2] ? !op[0] : (op[1:0] == 2'b01);
  assign a_neg    = a_signed && rs1_data[XLEN-1];
  assign b_neg    = b_signed && rs2_data[XLEN-1];
  assign a_mag    = a_neg ? -rs1_data : rs1_data;
  assign b_mag    = b_neg ? -rs2_data : rs2_data;
  // Remainder takes the dividend's sign; everything else the product of signs.
  assign res_neg  = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);

  assign div_zero = op[2] && (rs2_data == '0);
  assign div_ovf  = op[2] && !op[0] && (rs1_data == MIN_VAL) && (rs2_data == '1);

`ifdef ALU_MD_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod_mag, fast_prod;
  assign fast_prod_mag = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
  assign fast_prod     = res_neg ? -fast_prod_mag : fast_prod_mag;
  assign fast_mul      = !op[2];
`else
  assign fast_mul      = 1'b0;
`endif

  assign iterative = is_m && !div_zero && !div_ovf && !fast_mul;

  // Base ALU
  assign add_res = rs1_data + rs2_data;
  assign sub_res = rs1_data - rs2_data;
  assign shamt   = rs2_data[SHW-1:0];

  always_comb begin
    base_res = '0;
    base_ovf = 1'b0;
    case (op[3:0])
      ADD[3:0]: begin
        base_res = add_res;
        base_ovf = (rs1_data[XLEN-1] == rs2_data[XLEN-1]) &&
                   (add_res[XLEN-1] != rs1_data[XLEN-1]);
      end
      SUB[3:0]: begin
        base_res = sub_res;
        base_ovf = (rs1_data[XLEN-1] != rs2_data[XLEN-1]) &&
                   (sub_res[XLEN-1] != rs1_data[XLEN-1]);
      end
      SLT[3:0]:  base_res = XLEN'($signed(rs1_data) < $signed(rs2_data));
      SLTU[3:0]: base_res = XLEN'(rs1_data < rs2_data);
      SLL[3:0]:  base_res = rs1_data << shamt;
      XOR[3:0]:  base_res = rs1_data ^ rs2_data;
      SRL[3:0]:  base_res = rs1_data >> shamt;
      SRA[3:0]:  base_res = XLEN'($signed(rs1_data) >>> shamt);
      OR[3:0]:   base_res = rs1_data | rs2_data;
      AND[3:0]:  base_res = rs1_data & rs2_data;
      GE[3:0]:   base_res = XLEN'($signed(rs1_data) >= $signed(rs2_data));
      default:   base_res = '0;  // nop and reserved codes
    endcase
  end

  // Results that are ready in the accept cycle (base ops and fast paths)
  always_comb begin
    imm_res = base_res;
    imm_ovf = base_ovf;
    if (is_m) begin
      imm_ovf = 1'b0;
      if (div_zero)     imm_res = op[1] ? rs1_data : '1;
      else if (div_ovf) imm_res = op[1] ? '0 : MIN_VAL;
      else begin
`ifdef ALU_MD_FAST_MUL_EN
        imm_res = (op[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
        imm_res = '0;
`endif
      end
    end
  end

  alu_md_seq #(.XLEN(XLEN)) u_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (accept && iterative),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .is_div (op[2]),
    .done   (seq_done),
    .q      (seq_q),
    .hi     (seq_hi),
    .lo     (seq_lo)
  );

  // Sign correction applied in DONE
  assign prod_mag = {seq_hi, seq_lo};
  assign prod_seq = neg_reg ? -prod_mag : prod_mag;

  always_comb begin
    case (m_op_reg)
      MUL[2:0]:                       md_res = prod_seq[XLEN-1:0];
      MULH[2:0], MULHSU[2:0], MULHU[2:0]: md_res = prod_seq[2*XLEN-1:XLEN];
      DIV[2:0], DIVU[2:0]:            md_res = neg_reg ? -seq_q : seq_q;
      default:                        md_res = neg_reg ? -seq_hi : seq_hi;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    if (flush) state_next = IDLE;
    else begin
      case (state_reg)
        IDLE:    if (accept && iterative) state_next = BUSY;
        BUSY:    if (seq_done) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      m_op_reg      <= '0;
      neg_reg       <= 1'b0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else begin
      if (out_valid_reg && out_ready) out_valid_reg <= 1'b0;
      if (accept && !iterative) begin
        result_reg    <= imm_res;
        zero_reg      <= (imm_res == '0);
        overflow_reg  <= imm_ovf;
        out_valid_reg <= 1'b1;
      end
      if (accept && iterative) begin
        m_op_reg <= op[2:0];
        neg_reg  <= res_neg;
      end
      if (state_reg == DONE) begin
        result_reg    <= md_res;
        zero_reg      <= (md_res == '0);
        overflow_reg  <= 1'b0;
        out_valid_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_md_unit.sv
// tb_alu_md_unit: scoreboard bench for alu_md_unit (XLEN=32).
// Expected results are queued when an op is accepted and compared when the
// output handshake completes; first-visibility latency is checked too.
module tb_alu_md_unit;
  import alu_md_pkg::*;

  localparam logic [31:0] MINV = 32'h8000_0000;
`ifdef ALU_MD_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, zero, overflow;
  logic [4:0]  op;
  logic [31:0] rs1_data, rs2_data, result;

  always #5 clk = ~clk;

  alu_md_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow)
  );

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ov;
    int          acc;
    int          lat;
  } exp_t;

  exp_t scb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   head_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model, written from the ISA definitions
  function automatic logic [31:0] ref_res(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (o)
      ADD:    return a + b;
      SUB:    return a - b;
      SLT:    return 32'($signed(a) < $signed(b));
      SLTU:   return 32'(a < b);
      SLL:    return a << b[4:0];
      XOR:    return a ^ b;
      SRL:    return a >> b[4:0];
      SRA:    return 32'($signed(a) >>> b[4:0]);
      OR:     return a | b;
      AND:    return a & b;
      GE:     return 32'($signed(a) >= $signed(b));
      MUL:    begin p = 64'(ua * ub); return p[31:0]; end
      MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      DIV:    if (b == 0) return 32'hFFFF_FFFF;
              else if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
              else return 32'(sa / sb);
      DIVU:   if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      REM:    if (b == 0) return a;
              else if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
              else return 32'(sa % sb);
      REMU:   if (b == 0) return a; else return a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    longint s;
    if (o == ADD) s = longint'($signed(a)) + longint'($signed(b));
    else if (o == SUB) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic int ref_lat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    if (!o[4]) return 1;
    if (!o[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!o[0] && a == MINV && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Output monitor: latency on first sight of a result, values on handshake
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
        if (scb.size() == 0) check("unexpected_out_valid", 32'(out_valid), 32'h0);
        else begin
          if (!head_seen) begin
            head_seen = 1;
            check("latency", 32'(cyc - scb[0].acc + 1), 32'(scb[0].lat));
          end
          if (out_ready) begin
            check("result", result, scb[0].res);
            check("zero", 32'(zero), 32'(scb[0].z));
            check("overflow", 32'(overflow), 32'(scb[0].ov));
            void'(scb.pop_front());
            head_seen = 0;
          end
        end
      end
    end
  end

  // Present an op at a negedge and hold it until accepted; in_valid stays
  // high on return so the caller can chain ops back to back.
  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ez, input logic eo,
                       input int el, input bit push);
    exp_t e;
    bit   ok;
    ok = 0;
    op = o; rs1_data = a; rs2_data = b; in_valid = 1'b1;
    for (int w = 0; w < 200 && !ok; w++) begin
      #1;
      if (in_ready) begin
        ok = 1;
        if (push) begin
          e.res = er; e.z = ez; e.ov = eo; e.acc = cyc + 1; e.lat = el;
          scb.push_back(e);
        end
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 32'(in_ready), 32'h1);
      in_valid = 1'b0;
    end
  endtask

  task automatic issue_ref(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = ref_res(o, a, b);
    issue(o, a, b, r, r == 0, ref_ovf(o, a, b), ref_lat(o, a, b), 1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 200 && scb.size() != 0; w++) @(negedge clk);
    check("drain", 32'(scb.size()), 32'h0);
  endtask

  logic [4:0] op_tab [24] = '{ADD, SUB, SLT, SLTU, SLL, XOR, SRL, SRA, OR, AND, NOP, GE,
                              5'b01100, 5'b01111, MUL, MULH, MULHSU, MULHU,
                              DIV, DIVU, REM, REMU, DIV, REM};

  initial begin
    bit          seen;
    logic [31:0] a, b;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = '0;
    rs1_data = '0; rs2_data = '0; out_ready = 1'b1;

    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_zero", 32'(zero), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);

    // Base ops back to back: each must appear 1 cycle after accept
    issue(ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1, 1, 1);
    issue(SUB, 32'd5, 32'd5, 32'h0, 1, 0, 1, 1);
    issue(SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, 0, 0, 1, 1);
    issue(SLTU, 32'h1, 32'hFFFF_FFFF, 32'h1, 0, 0, 1, 1);
    issue(SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 0, 1, 1, 1);
    issue(5'b01101, 32'h1234, 32'h5678, 32'h0, 1, 0, 1, 1);
    idle();

    // M ops
    issue(MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1, 0, MUL_LAT, 1);
    issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, MUL_LAT, 1);
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 0, 34, 1);
    issue(REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 0, 34, 1);
    issue(DIVU, 32'd1234, 32'd0, 32'hFFFF_FFFF, 0, 0, 1, 1);
    issue(REMU, 32'd1234, 32'd0, 32'd1234, 0, 0, 1, 1);
    issue(DIV, MINV, 32'hFFFF_FFFF, MINV, 0, 0, 1, 1);
    issue(REM, MINV, 32'hFFFF_FFFF, 32'h0, 1, 0, 1, 1);
    idle();

    // Random mix against the reference model
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 5) == 0) ? MINV : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      issue_ref(op_tab[$urandom_range(0, 23)], a, b);
    end
    idle();
    drain();

    // Output hold with out_ready low for 5 cycles
    out_ready = 1'b0;
    issue(ADD, 32'd3, 32'd4, 32'd7, 0, 0, 1, 1);
    idle();
    for (int i = 0; i < 5; i++) begin
      #3;
      check("hold_result", result, 32'd7);
      check("hold_out_valid", 32'(out_valid), 32'h1);
      check("hold_in_ready", 32'(in_ready), 32'h0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    drain();

    // Flush at about iteration 10 of a divide
    issue(DIV, 32'd100000, 32'd7, 32'h0, 0, 0, 0, 0);
    idle();
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'h1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      seen |= out_valid;
    end
    check("flush_no_out", 32'(seen), 32'h0);

    // Input presented during a flush cycle is dropped
    flush = 1'b1;
    op = ADD; rs1_data = 32'd1; rs2_data = 32'd1; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_drop_input", 32'(out_valid), 32'h0);
    @(negedge clk);

    // Asynchronous reset in the middle of a multiply
    issue(ADD, 32'd1, 32'd1, 32'd2, 0, 0, 1, 1);
    idle();
    @(negedge clk);
    drain();
    issue(MULHU, 32'hFFFF_FFFF, 32'h2, 32'h0, 0, 0, 0, 0);
    idle();
    repeat (3) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'h0);
    check("arst_result", result, 32'h0);
    check("arst_zero", 32'(zero), 32'h0);
    check("arst_overflow", 32'(overflow), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    head_seen = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      seen |= out_valid;
    end
    check("arst_no_out", 32'(seen), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
